sccb_target: RTL and testbench
==============================

# sccb_target

SCCB target (camera-side responder) for the 3-wire SCCB bus that `SCCB_CTRL` drives as initiator. It oversamples SIO_C/SIO_D on XCLK, decodes start/stop and the 3-phase write, 2-phase write and 2-phase read transactions, and converts them into a simple register-port interface. It serves as the OV2640-style bus-functional responder in initiator benches, and as the front end of an on-chip register bank.

## Interface
- DEV_ID, 8'h60, write ID; read ID is DEV_ID|1 (8'h61)
- SYNC_STAGES, 2, synchroniser depth on SIO_C/SIO_D (≥2)
- XCLK  in  1  clock; one clock domain; SIO_C period ≥ 8 XCLK
- RST  in  1  reset, synchronous, active-high
- SIO_C  in  1  bus clock from initiator
- SIO_D_IN  in  1  bus data as seen on pad
- SIO_D_OE  out  1  1 = pull SIO_D low (open-drain); 0 = release
- reg_addr  out  8  current sub-address (read/write pointer)
- reg_wdata  out  8  write data, valid with reg_wr_en
- reg_wr_en  out  1  one-cycle write strobe
- reg_rd_en  out  1  one-cycle read request
- reg_rdata  in  8  read data, sampled the cycle after reg_rd_en
- busy  out  1  high between accepted start and stop

## Operation
- Reset: state IDLE; SIO_D_OE, reg_wr_en, reg_rd_en, busy = 0; reg_addr, reg_wdata = 8'h00.
- Start = SIO_D falls while SIO_C high; stop = SIO_D rises while SIO_C high. Start in any state (including repeated start) → ID with bit count 0. Stop in any state → IDLE; a partial byte is discarded with no strobe.
- Bits are sampled on synchronised SIO_C rising edges, MSB first, 8 data bits plus the 9th "don't-care" bit per phase.
- States: IDLE, ID, ID_X, SUB, SUB_X, WDATA, WDATA_X, RDATA, RDATA_X, IGNORE.
- ID: after 8 bits, the byte is compared with DEV_ID/DEV_ID|1. A mismatch → IGNORE until stop or start. A write ID → ID_X → SUB. A read ID → pulse reg_rd_en (reg_addr unchanged) → ID_X → RDATA.
- SUB: 8th bit → reg_addr ← byte → SUB_X → WDATA. A stop here completes the 2-phase write (the pointer is set; no strobe).
- WDATA: 8th bit → reg_wdata ← byte, reg_wr_en pulses 1 cycle → WDATA_X → IGNORE. There is no auto-increment; any extra bytes are ignored.
- RDATA: reg_rdata is loaded into the shift register the cycle after reg_rd_en. Each bit is placed on SIO_D after the SIO_C falling edge that ends the previous bit (the first bit follows the ID 9th-bit falling edge). SIO_D_OE = ~bit. After 8 bits → RDATA_X: SIO_D_OE = 0 and the NA bit is sampled → IGNORE.
- SIO_D_OE is forced to 0 in every state except RDATA, and in the ACK slot (see Configuration).

## Timing
- Pin-to-event latency: SYNC_STAGES + 1 XCLK (default 3).
- reg_wr_en/reg_rd_en assert 1 cycle after the event for the 8th rising edge. Each is exactly one cycle wide, and at most one strobe occurs per phase.
- SIO_D_OE changes 1 cycle after the detected SIO_C falling edge. It is never changed while synchronised SIO_C is high, so the target can never create a false start or stop.
- Start and stop detected in the same cycle cannot occur; stop has priority if it does.
- RST asserted mid-transfer: the next cycle is the reset state. SIO_D_OE drops immediately on that edge, and no strobe is issued.

## Configuration
- SCCB_TGT_ACK_EN defined: in ID_X (address matched), SUB_X and WDATA_X the target holds SIO_D_OE = 1 from the falling edge that opens the 9th bit to the falling edge that closes it (OV-sensor-style ACK).
- Not defined: SIO_D_OE stays 0 during all 9th bits (pure SCCB don't-care).

## Structure
- Package sccb_pkg: state enum, SCCB_RD_BIT = 0 (LSB of the ID), default DEV_ID constant 8'h60, and bit-count width.
- Sub-module sccb_tgt_sync: SYNC_STAGES flops on SIO_C/SIO_D plus the previous-value register. It outputs scl_rise, scl_fall, start_det, stop_det and the synchronised levels.
- The top level holds the FSM, 3-bit bit counter, 8-bit shift register and output registers.

## Test plan
- 3-phase write 60/EE/5A → one reg_wr_en pulse with reg_addr = EE and reg_wdata = 5A. busy falls after stop.
- 2-phase write 60/0A + stop, then read 61 with reg_rdata = 8'h26 → reg_rd_en fires with reg_addr = 0A. SIO_D shows 0,0,1,0,0,1,1,0 and SIO_D_OE = 0 in the NA bit.
- ID 42/EE/11 → no strobes, SIO_D_OE = 0 throughout, and reg_addr keeps its prior value.
- 60/EE then stop after 4 data bits → reg_addr = EE and no reg_wr_en. Repeated start mid-byte restarts the ID phase correctly.
- RST asserted at bit 3 of a read → SIO_D_OE = 0 on the next cycle and state IDLE. A following 3-phase write succeeds.
- With SCCB_TGT_ACK_EN, transfer 60/EE/5A → SIO_D_OE = 1 in all three 9th bits. Without the macro it is 0 in all three.

Source files
------------

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared definitions for the SCCB target.
//   sccb_state_e - transaction FSM states (x = 9th "don't-care" bit of a phase)
//   SCCB_RD_BIT  - ID bit that selects a read transaction
//   SCCB_DEV_ID  - default write ID
//   SCCB_CNT_W   - width of the in-byte bit counter
package sccb_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StId,
        StIdX,
        StSub,
        StSubX,
        StWdata,
        StWdataX,
        StRdata,
        StRdataX,
        StIgnore
    } sccb_state_e;

    localparam int unsigned SCCB_RD_BIT = 0;
    localparam logic [7:0]  SCCB_DEV_ID = 8'h60;
    localparam int unsigned SCCB_CNT_W  = 3;

endpackage

// File: rtl/sccb_tgt_sync.sv
// sccb_tgt_sync: synchroniser and bus-event detector for SIO_C/SIO_D.
//   clk_i, rst_i     - XCLK and synchronous active-high reset
//   scl_i, sda_i     - raw pad levels
//   sda_o            - synchronised SIO_D level
//   scl_rise_o/fall_o - one-cycle pulses on synchronised SIO_C edges
//   start_det_o      - SIO_D fell while SIO_C high
//   stop_det_o       - SIO_D rose while SIO_C high
module sccb_tgt_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_now;
    logic                   sda_now;

    // Reset to the idle bus level so releasing reset never fakes an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_now;
            sda_prev_q <= sda_now;
        end
    end

    assign scl_now = scl_sync_q[SYNC_STAGES-1];
    assign sda_now = sda_sync_q[SYNC_STAGES-1];

    assign sda_o       = sda_now;
    assign scl_rise_o  = scl_now & ~scl_prev_q;
    assign scl_fall_o  = ~scl_now & scl_prev_q;
    // SIO_C must be high in both samples so a data change near an edge is ignored.
    assign start_det_o = scl_now & scl_prev_q & sda_prev_q & ~sda_now;
    assign stop_det_o  = scl_now & scl_prev_q & ~sda_prev_q & sda_now;

endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB camera-side responder feeding a simple register port.
//   XCLK, RST          - clock and synchronous active-high reset
//   SIO_C, SIO_D_IN    - bus clock and data as seen on the pads
//   SIO_D_OE           - 1 pulls SIO_D low (open drain)
//   reg_addr           - sub-address pointer set by the second phase
//   reg_wdata/wr_en    - write data with a one-cycle strobe
//   reg_rd_en/rdata    - one-cycle read request, data sampled the following cycle
//   busy               - high between an accepted start and a stop
// Build option: define SCCB_TGT_ACK_EN to drive SIO_D low during the 9th bit of
// matched ID, sub-address and write-data phases (OV-sensor-style ACK).
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [7:0]  DEV_ID      = SCCB_DEV_ID,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       XCLK,
    input  logic       RST,
    input  logic       SIO_C,
    input  logic       SIO_D_IN,
    output logic       SIO_D_OE,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam logic [7:0] RD_MASK = 8'(1) << SCCB_RD_BIT;
    localparam logic [7:0] WR_ID   = DEV_ID & ~RD_MASK;
    localparam logic [7:0] RD_ID   = DEV_ID | RD_MASK;

`ifdef SCCB_TGT_ACK_EN
    localparam logic ACK_DRIVE = 1'b1;
`else
    localparam logic ACK_DRIVE = 1'b0;
`endif

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    sccb_tgt_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i       (XCLK),
        .rst_i       (RST),
        .scl_i       (SIO_C),
        .sda_i       (SIO_D_IN),
        .sda_o       (sda),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det)
    );

    sccb_state_e           state_q;
    logic [SCCB_CNT_W-1:0] bit_cnt_q;
    logic [7:0]            shift_q;
    logic                  ninth_q;    // X states: 9th rising edge seen; RDATA: 8th edge seen
    logic                  rd_mode_q;  // ID phase carried the read ID
    logic                  rd_load_q;  // load reg_rdata this cycle
    logic [7:0]            byte_in;
    logic                  last_bit;

    assign byte_in  = {shift_q[6:0], sda};
    assign last_bit = (bit_cnt_q == 3'd7);

    always_ff @(posedge XCLK) begin
        if (RST) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= 8'h00;
            ninth_q   <= 1'b0;
            rd_mode_q <= 1'b0;
            rd_load_q <= 1'b0;
            SIO_D_OE  <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            rd_load_q <= reg_rd_en;
            // Registered register banks return data the cycle after the request.
            if (rd_load_q) begin
                shift_q <= reg_rdata;
            end

            if (stop_det) begin
                state_q   <= StIdle;
                bit_cnt_q <= '0;
                ninth_q   <= 1'b0;
                SIO_D_OE  <= 1'b0;
                busy      <= 1'b0;
            end else if (start_det) begin
                state_q   <= StId;
                bit_cnt_q <= '0;
                ninth_q   <= 1'b0;
                SIO_D_OE  <= 1'b0;
                busy      <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle, StIgnore: begin
                        SIO_D_OE <= 1'b0;
                    end

                    StId: begin
                        SIO_D_OE <= 1'b0;
                        if (scl_rise) begin
                            shift_q   <= byte_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                ninth_q <= 1'b0;
                                if (byte_in == WR_ID) begin
                                    rd_mode_q <= 1'b0;
                                    state_q   <= StIdX;
                                end else if (byte_in == RD_ID) begin
                                    rd_mode_q <= 1'b1;
                                    reg_rd_en <= 1'b1;
                                    state_q   <= StIdX;
                                end else begin
                                    state_q <= StIgnore;
                                end
                            end
                        end
                    end

                    StSub: begin
                        SIO_D_OE <= 1'b0;
                        if (scl_rise) begin
                            shift_q   <= byte_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                reg_addr <= byte_in;
                                ninth_q  <= 1'b0;
                                state_q  <= StSubX;
                            end
                        end
                    end

                    StWdata: begin
                        SIO_D_OE <= 1'b0;
                        if (scl_rise) begin
                            shift_q   <= byte_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                reg_wdata <= byte_in;
                                reg_wr_en <= 1'b1;
                                ninth_q   <= 1'b0;
                                state_q   <= StWdataX;
                            end
                        end
                    end

                    // The falling edge before the 9th rising edge opens the slot,
                    // the one after it closes the slot and moves on.
                    StIdX, StSubX, StWdataX: begin
                        if (scl_rise) begin
                            ninth_q <= 1'b1;
                        end
                        if (scl_fall) begin
                            if (!ninth_q) begin
                                SIO_D_OE <= ACK_DRIVE;
                            end else begin
                                ninth_q   <= 1'b0;
                                bit_cnt_q <= '0;
                                SIO_D_OE  <= 1'b0;
                                if (state_q == StIdX && rd_mode_q) begin
                                    state_q  <= StRdata;
                                    SIO_D_OE <= ~shift_q[7];
                                end else if (state_q == StIdX) begin
                                    state_q <= StSub;
                                end else if (state_q == StSubX) begin
                                    state_q <= StWdata;
                                end else begin
                                    state_q <= StIgnore;
                                end
                            end
                        end
                    end

                    // OE only ever moves on a falling edge, so the target cannot
                    // fake a start or stop.
                    StRdata: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                ninth_q <= 1'b1;
                            end
                        end
                        if (scl_fall) begin
                            if (ninth_q) begin
                                ninth_q  <= 1'b0;
                                SIO_D_OE <= 1'b0;
                                state_q  <= StRdataX;
                            end else begin
                                shift_q  <= {shift_q[6:0], 1'b0};
                                SIO_D_OE <= ~shift_q[6];
                            end
                        end
                    end

                    // NA bit from the initiator: nothing to act on.
                    StRdataX: begin
                        SIO_D_OE <= 1'b0;
                        if (scl_rise) begin
                            state_q <= StIgnore;
                        end
                    end

                    default: begin
                        SIO_D_OE <= 1'b0;
                        state_q  <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
module tb_sccb_target;

    logic       XCLK = 1'b0;
    logic       RST = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       SIO_D_OE;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rdata = 8'h26;
    logic       busy;

`ifdef SCCB_TGT_ACK_EN
    localparam logic ACK_EXP = 1'b1;
`else
    localparam logic ACK_EXP = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    assign sda_bus = sda_m & ~SIO_D_OE;

    always #5 XCLK = ~XCLK;

    sccb_target dut (
        .XCLK      (XCLK),
        .RST       (RST),
        .SIO_C     (scl_m),
        .SIO_D_IN  (sda_bus),
        .SIO_D_OE  (SIO_D_OE),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Strobe monitor: counts, captured values, back-to-back detection.
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         oe_cycles = 0;
    int         wide_cnt = 0;
    logic       wr_prev = 1'b0;
    logic       rd_prev = 1'b0;
    logic [7:0] cap_waddr = 8'h00;
    logic [7:0] cap_wdata = 8'h00;
    logic [7:0] cap_raddr = 8'h00;

    always @(posedge XCLK) begin
        wr_prev <= reg_wr_en;
        rd_prev <= reg_rd_en;
        if (SIO_D_OE) oe_cycles <= oe_cycles + 1;
        if ((reg_wr_en && wr_prev) || (reg_rd_en && rd_prev)) wide_cnt <= wide_cnt + 1;
        if (reg_wr_en) begin
            wr_cnt    <= wr_cnt + 1;
            cap_waddr <= reg_addr;
            cap_wdata <= reg_wdata;
        end
        if (reg_rd_en) begin
            rd_cnt    <= rd_cnt + 1;
            cap_raddr <= reg_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Quarter SIO_C period = 4 XCLK; inputs change on the falling XCLK edge.
    task automatic q();
        repeat (4) @(negedge XCLK);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic clk_bit(input logic b, output logic rd, output logic oe);
        sda_m = b;    q();
        scl_m = 1'b1; q();
        rd = sda_bus;
        oe = SIO_D_OE;
        q();
        scl_m = 1'b0; q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] rd, output logic ack_oe);
        logic r;
        logic o;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(b[i], r, o);
            rd[i] = r;
        end
        clk_bit(1'b1, r, ack_oe);
    endtask

    initial begin
        logic [7:0] rb;
        logic       ack;
        logic       r;
        logic       o;
        int         wr0;
        int         rd0;
        int         oe0;

        repeat (3) @(negedge XCLK);
        RST = 1'b0;
        @(negedge XCLK);
        chk("rst_oe", SIO_D_OE, 0);
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_rd_en", reg_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", reg_addr, 8'h00);
        chk("rst_wdata", reg_wdata, 8'h00);

        // 3-phase write 60/EE/5A
        wr0 = wr_cnt;
        bus_start();
        chk("w3_busy_on", busy, 1);
        send_byte(8'h60, rb, ack); chk("w3_ack_id", ack, ACK_EXP);
        send_byte(8'hEE, rb, ack); chk("w3_ack_sub", ack, ACK_EXP);
        send_byte(8'h5A, rb, ack); chk("w3_ack_data", ack, ACK_EXP);
        bus_stop();
        q();
        chk("w3_wr_cnt", wr_cnt - wr0, 1);
        chk("w3_cap_addr", cap_waddr, 8'hEE);
        chk("w3_cap_wdata", cap_wdata, 8'h5A);
        chk("w3_addr", reg_addr, 8'hEE);
        chk("w3_busy_off", busy, 0);

        // 2-phase write 60/0A, then read 61 returning 26
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        bus_start();
        send_byte(8'h60, rb, ack);
        send_byte(8'h0A, rb, ack); chk("w2_ack_sub", ack, ACK_EXP);
        bus_stop();
        q();
        chk("w2_addr", reg_addr, 8'h0A);
        chk("w2_no_wr", wr_cnt - wr0, 0);
        bus_start();
        send_byte(8'h61, rb, ack); chk("rd_ack_id", ack, ACK_EXP);
        chk("rd_rd_cnt", rd_cnt - rd0, 1);
        chk("rd_cap_addr", cap_raddr, 8'h0A);
        send_byte(8'hFF, rb, ack);
        chk("rd_data", rb, 8'h26);
        chk("rd_na_oe", ack, 0);
        bus_stop();
        q();
        chk("rd_addr_kept", reg_addr, 8'h0A);
        chk("rd_busy_off", busy, 0);

        // Foreign ID 42/EE/11: ignored entirely
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        oe0 = oe_cycles;
        bus_start();
        send_byte(8'h42, rb, ack);
        send_byte(8'hEE, rb, ack);
        send_byte(8'h11, rb, ack);
        bus_stop();
        q();
        chk("nid_no_wr", wr_cnt - wr0, 0);
        chk("nid_no_rd", rd_cnt - rd0, 0);
        chk("nid_no_oe", oe_cycles - oe0, 0);
        chk("nid_addr", reg_addr, 8'h0A);

        // 60/EE then stop after 4 data bits: pointer set, no write
        wr0 = wr_cnt;
        bus_start();
        send_byte(8'h60, rb, ack);
        send_byte(8'hEE, rb, ack);
        for (int i = 0; i < 4; i++) clk_bit(i[0], r, o);
        bus_stop();
        q();
        chk("part_addr", reg_addr, 8'hEE);
        chk("part_no_wr", wr_cnt - wr0, 0);
        chk("part_busy", busy, 0);

        // Repeated start mid-byte, then 60/33/C3
        wr0 = wr_cnt;
        bus_start();
        send_byte(8'h60, rb, ack);
        for (int i = 0; i < 3; i++) clk_bit(1'b0, r, o);
        bus_start();
        send_byte(8'h60, rb, ack);
        send_byte(8'h33, rb, ack);
        send_byte(8'hC3, rb, ack);
        bus_stop();
        q();
        chk("rs_wr_cnt", wr_cnt - wr0, 1);
        chk("rs_cap_addr", cap_waddr, 8'h33);
        chk("rs_cap_wdata", cap_wdata, 8'hC3);

        // Reset during bit 3 of a read (bit value 0 -> target pulling low)
        bus_start();
        send_byte(8'h61, rb, ack);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, r, o);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        chk("rrst_oe_before", SIO_D_OE, 1);
        RST = 1'b1;
        @(posedge XCLK);
        #1;
        chk("rrst_oe_after", SIO_D_OE, 0);
        chk("rrst_busy", busy, 0);
        @(negedge XCLK);
        RST = 1'b0;
        q();
        scl_m = 1'b0; q();
        bus_stop();
        q();

        wr0 = wr_cnt;
        bus_start();
        send_byte(8'h60, rb, ack);
        send_byte(8'h71, rb, ack);
        send_byte(8'h9C, rb, ack);
        bus_stop();
        q();
        chk("post_wr_cnt", wr_cnt - wr0, 1);
        chk("post_addr", reg_addr, 8'h71);
        chk("post_wdata", reg_wdata, 8'h9C);
        chk("strobe_width", wide_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
